// File: rtl/batch_stream_pkg.sv
// Shared types and sizing helpers for the overlapping-batch stream (source and reassembler).
package batch_stream_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, GAP, DRAIN} state_e;

  function automatic int tot_size(input int batch_size, input int runs);
    return batch_size + runs - 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/batch_ram.sv
// TOT_SIZE x DATA_WIDTH sample buffer: one synchronous write port, two asynchronous read ports.
module batch_ram #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_cmp_addr,
  output logic [DATA_WIDTH-1:0] o_cmp_data,
  input  logic [ADDR_WIDTH-1:0] i_drain_addr,
  output logic [DATA_WIDTH-1:0] o_drain_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage arrays carry no reset; every entry read during a drain is written earlier in the frame.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_cmp_data   = r_mem[i_cmp_addr];
  assign o_drain_data = r_mem[i_drain_addr];

endmodule

// File: rtl/batch_reassembler.sv
// Rebuilds the original sample sequence from RUNS overlapping batches, cross-checks the overlap,
// and drains the result as one ready/valid packet.
module batch_reassembler
  import batch_stream_pkg::*;
#(
  parameter int BATCH_SIZE = 8,
  parameter int RUNS       = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sink_sop,
  input  logic                  sink_eop,
  input  logic                  sink_valid,
  input  logic [DATA_WIDTH-1:0] sink_data,
  input  logic                  source_ready,
  output logic                  source_valid,
  output logic                  source_sop,
  output logic                  source_eop,
  output logic [DATA_WIDTH-1:0] source_data,
  output logic                  frame_done,
  output logic                  err_framing,
  output logic                  err_mismatch,
  output logic                  err_overrun
);

  localparam int TOT_SIZE = tot_size(BATCH_SIZE, RUNS);
  localparam int CW       = cnt_width(TOT_SIZE);
  localparam int AW       = (TOT_SIZE > 1) ? $clog2(TOT_SIZE) : 1;

  localparam logic [CW-1:0] LAST_I = CW'(BATCH_SIZE - 1);
  localparam logic [CW-1:0] LAST_B = CW'(RUNS - 1);
  localparam logic [CW-1:0] LAST_K = CW'(TOT_SIZE - 1);

  state_e                r_state, w_next_state;
  logic [CW-1:0]         r_b, r_i, r_k;
  logic [CW-1:0]         w_pos, w_drain_k;
  logic                  w_beat, w_bad_frame, w_store, w_mismatch;
  logic                  w_handshake, w_last_beat, w_enter_drain;
  logic [DATA_WIDTH-1:0] w_cmp_data, w_drain_data, w_first_data;
  logic                  r_valid, r_frame_done;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err_framing, r_err_mismatch, r_err_overrun;

  assign w_pos       = r_b + r_i;
  assign w_handshake = (r_state == DRAIN) && r_valid && source_ready;
  assign w_last_beat = w_handshake && (r_k == LAST_K);
  // Drain read address runs one entry ahead so back-to-back handshakes never bubble.
  assign w_drain_k   = (r_state == DRAIN && r_k != LAST_K) ? r_k + 1'b1 : '0;

  batch_ram #(
    .DEPTH      (TOT_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk          (clk),
    .i_wr_en      (w_store),
    .i_wr_addr    (w_pos[AW-1:0]),
    .i_wr_data    (sink_data),
    .i_cmp_addr   (w_pos[AW-1:0]),
    .o_cmp_data   (w_cmp_data),
    .i_drain_addr (w_drain_k[AW-1:0]),
    .o_drain_data (w_drain_data)
  );

  // NOTE: every signal assigned here gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_beat       = 1'b0;
    w_bad_frame  = 1'b0;
    w_store      = 1'b0;
    w_mismatch   = 1'b0;
    unique case (r_state)
      IDLE:         w_beat = sink_valid && sink_sop;
      COLLECT, GAP: w_beat = sink_valid;
      DRAIN:        if (w_last_beat) w_next_state = IDLE;
      default:      w_next_state = IDLE;
    endcase
    if (w_beat) begin
      // sop must mark exactly entry 0 and eop exactly the last entry of a batch.
      w_bad_frame = (sink_sop != (r_i == '0)) || (sink_eop != (r_i == LAST_I));
      if (w_bad_frame) begin
        w_next_state = IDLE;
      end else begin
        w_store      = (r_b == '0) || (r_i == LAST_I);
        w_mismatch   = !w_store && (w_cmp_data != sink_data);
        w_next_state = !sink_eop ? COLLECT : (r_b == LAST_B) ? DRAIN : GAP;
      end
    end
  end

  assign w_enter_drain = (r_state != DRAIN) && (w_next_state == DRAIN);
  // Only a single-entry frame can write entry 0 on its final beat; forward it.
  assign w_first_data  = (w_store && w_pos[AW-1:0] == w_drain_k[AW-1:0]) ? sink_data : w_drain_data;

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (reset || w_bad_frame || w_last_beat) begin
      r_b <= '0;
      r_i <= '0;
      r_k <= '0;
    end else begin
      if (w_beat) begin
        if (sink_eop) begin
          if (r_b != LAST_B) r_b <= r_b + 1'b1;
          r_i <= '0;
        end else begin
          r_i <= r_i + 1'b1;
        end
      end
      if (w_handshake) r_k <= r_k + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_data         <= '0;
      r_frame_done   <= 1'b0;
      r_err_framing  <= 1'b0;
      r_err_mismatch <= 1'b0;
      r_err_overrun  <= 1'b0;
    end else begin
      r_frame_done <= w_last_beat;
      if (w_enter_drain) begin
        r_valid <= 1'b1;
        r_data  <= w_first_data;
      end else if (w_last_beat) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else if (w_handshake) begin
        r_data  <= w_drain_data;
      end
      if (w_bad_frame)                       r_err_framing  <= 1'b1;
      if (w_mismatch)                        r_err_mismatch <= 1'b1;
      if (r_state == DRAIN && sink_valid)    r_err_overrun  <= 1'b1;
    end
  end

  assign source_valid = r_valid;
  assign source_sop   = r_valid && (r_k == '0);
  assign source_eop   = r_valid && (r_k == LAST_K);
  assign source_data  = r_data;
  assign frame_done   = r_frame_done;
  assign err_framing  = r_err_framing;
  assign err_mismatch = r_err_mismatch;
  assign err_overrun  = r_err_overrun;

endmodule

// File: tb/tb_batch_reassembler.sv
// Directed bench for batch_reassembler: scoreboard of expected drain beats, stall-stability monitor,
// framing/mismatch/overrun/reset scenarios, plus a single-entry-frame instance.
module tb_batch_reassembler;

  logic       clk;
  logic       reset;
  logic       sink_sop, sink_eop, sink_valid;
  logic [7:0] sink_data;
  logic       source_ready;
  logic       source_valid, source_sop, source_eop;
  logic [7:0] source_data;
  logic       frame_done, err_framing, err_mismatch, err_overrun;

  logic       s_sop, s_eop, s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       s_out_valid, s_out_sop, s_out_eop;
  logic [7:0] s_out_data;
  logic       s_done, s_err_framing, s_err_mismatch, s_err_overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_done   = 0;

  logic [9:0] sb [$];
  logic       mon_stall;
  logic [10:0] mon_hold;

  batch_reassembler #(.BATCH_SIZE(4), .RUNS(3), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_valid(sink_valid), .sink_data(sink_data),
    .source_ready(source_ready),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .source_data(source_data), .frame_done(frame_done),
    .err_framing(err_framing), .err_mismatch(err_mismatch), .err_overrun(err_overrun)
  );

  batch_reassembler #(.BATCH_SIZE(1), .RUNS(1), .DATA_WIDTH(8)) dut_small (
    .clk(clk), .reset(reset),
    .sink_sop(s_sop), .sink_eop(s_eop), .sink_valid(s_valid), .sink_data(s_data),
    .source_ready(s_ready),
    .source_valid(s_out_valid), .source_sop(s_out_sop), .source_eop(s_out_eop),
    .source_data(s_out_data), .frame_done(s_done),
    .err_framing(s_err_framing), .err_mismatch(s_err_mismatch), .err_overrun(s_err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every handshake; outputs must hold while valid is stalled.
  always @(negedge clk) begin
    if (reset) begin
      mon_stall = 1'b0;
    end else begin
      if (mon_stall)
        check("stall_hold", {21'b0, source_valid, source_sop, source_eop, source_data}, {21'b0, mon_hold});
      if (source_valid && source_ready) begin
        check("beat_expected", sb.size() > 0, 1);
        if (sb.size() > 0) check("beat", {source_sop, source_eop, source_data}, sb.pop_front());
      end
      mon_stall = source_valid && !source_ready;
      mon_hold  = {source_valid, source_sop, source_eop, source_data};
      if (frame_done) n_done++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    step();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic beat(input logic sop, input logic eop, input logic [7:0] d);
    sink_valid = 1'b1; sink_sop = sop; sink_eop = eop; sink_data = d;
    step();
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
  endtask

  // Three batches of the sequence 10..15; b2e0 replaces batch 2 entry 0 (normally 12).
  task automatic send_frame(input logic [7:0] b2e0, input int gap);
    for (int k = 0; k < 6; k++) sb.push_back({k == 0, k == 5, 8'(10 + k)});
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++)
        beat(i == 0, i == 3, (b == 2 && i == 0) ? b2e0 : 8'(10 + b + i));
      if (b < 2) idle(gap);
    end
  endtask

  task automatic wait_done(input bit toggle, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 100) begin
      source_ready = toggle ? ~source_ready : 1'b1;
      step();
      cycles++;
      if (frame_done) seen = 1'b1;
    end
    source_ready = 1'b1;
  endtask

  initial begin
    int  cyc;
    bit  seen;
    int  done0;
    mon_stall = 1'b0;
    mon_hold  = '0;
    source_ready = 1'b1;
    s_ready = 1'b1;
    sink_data = '0;
    s_data = '0;
    #1;
    do_reset();

    // Reset state
    check("reset_outputs", {source_valid, source_sop, source_eop, frame_done}, 0);
    check("reset_flags", {err_framing, err_mismatch, err_overrun}, 0);

    // 1: clean frame, ready held high
    done0 = n_done;
    send_frame(8'd12, 0);
    check("t1_latency", {source_valid, source_sop, source_eop, source_data}, {3'b110, 8'd10});
    wait_done(1'b0, cyc, seen);
    check("t1_done_seen", seen, 1);
    check("t1_done_cycles", cyc, 6);
    check("t1_valid_drop", source_valid, 0);
    idle(1);
    check("t1_done_pulse", frame_done, 0);
    check("t1_done_count", n_done - done0, 1);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_flags", {err_framing, err_mismatch, err_overrun}, 0);

    // 2: same frame with an idle gap, ready toggling
    do_reset();
    done0 = n_done;
    source_ready = 1'b1;
    send_frame(8'd12, 2);
    check("t2_latency", {source_valid, source_data}, {1'b1, 8'd10});
    wait_done(1'b1, cyc, seen);
    check("t2_done_seen", seen, 1);
    idle(1);
    check("t2_done_count", n_done - done0, 1);
    check("t2_sb_empty", sb.size(), 0);
    check("t2_flags", {err_framing, err_mismatch, err_overrun}, 0);

    // 3: overlap mismatch keeps the stored copy
    do_reset();
    done0 = n_done;
    send_frame(8'h55, 0);
    check("t3_mismatch", err_mismatch, 1);
    wait_done(1'b0, cyc, seen);
    check("t3_done_seen", seen, 1);
    idle(1);
    check("t3_sb_empty", sb.size(), 0);
    check("t3_other_flags", {err_framing, err_overrun}, 0);

    // 4: early eop in batch 0, then a valid frame
    do_reset();
    done0 = n_done;
    beat(1'b1, 1'b0, 8'd10);
    beat(1'b0, 1'b0, 8'd11);
    beat(1'b0, 1'b1, 8'd12);
    check("t4_framing", err_framing, 1);
    idle(3);
    check("t4_no_output", source_valid, 0);
    check("t4_no_done", n_done - done0, 0);
    send_frame(8'd12, 1);
    check("t4_latency", {source_valid, source_sop, source_data}, {2'b11, 8'd10});
    wait_done(1'b0, cyc, seen);
    check("t4_done_cycles", cyc, 6);
    idle(1);
    check("t4_sb_empty", sb.size(), 0);
    check("t4_framing_sticky", err_framing, 1);

    // 5: overrun during drain, then reset on drain beat 3
    do_reset();
    done0 = n_done;
    source_ready = 1'b0;
    send_frame(8'd12, 0);
    beat(1'b1, 1'b0, 8'h77);
    beat(1'b1, 1'b1, 8'h78);
    check("t5_overrun", err_overrun, 1);
    check("t5_held", {source_valid, source_sop, source_data}, {2'b11, 8'd10});
    source_ready = 1'b1;
    idle(3);
    check("t5_beat3", {source_valid, source_sop, source_eop, source_data}, {3'b100, 8'd13});
    check("t5_sb_left", sb.size(), 3);
    reset = 1'b1;
    source_ready = 1'b0;
    step();
    reset = 1'b0;
    sb.delete();
    check("t5_reset_valid", source_valid, 0);
    check("t5_reset_flags", {err_framing, err_mismatch, err_overrun}, 0);
    check("t5_reset_done", frame_done, 0);
    source_ready = 1'b1;
    idle(8);
    check("t5_no_done", n_done - done0, 0);
    check("t5_still_idle", source_valid, 0);

    // 6: single-entry frame on the BATCH_SIZE=1, RUNS=1 instance
    s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b1; s_data = 8'hA5;
    step();
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    check("t6_beat", {s_out_valid, s_out_sop, s_out_eop, s_out_data}, {3'b111, 8'hA5});
    step();
    check("t6_done", {s_done, s_out_valid}, 2'b10);
    check("t6_flags", {s_err_framing, s_err_mismatch, s_err_overrun}, 0);
    step();
    check("t6_done_pulse", s_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
